fir_output_range_monitor: RTL



---
 rtl/fir_output_range_monitor_if.sv | 28 ++
 rtl/fir_output_range_monitor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fir_output_range_monitor_if.sv
// Sample stream and window-result port of the FIR output range monitor.
// master drives samples and consumes results; slave is the monitor.
interface fir_output_range_monitor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         data_valid;
  logic                         restart;
  logic                         result_ready;
  logic                         result_valid;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic signed [DATA_WIDTH-1:0] min_val;
  logic        [DATA_WIDTH-1:0] peak_abs;
  logic        [CNT_WIDTH-1:0]  clip_count;
  logic                         overrun;
  logic                         busy;

  modport master (
    output data_in, data_valid, restart, result_ready,
    input  result_valid, max_val, min_val, peak_abs, clip_count, overrun, busy
  );

  modport slave (
    input  data_in, data_valid, restart, result_ready,
    output result_valid, max_val, min_val, peak_abs, clip_count, overrun, busy
  );
endinterface

// File: rtl/fir_output_range_monitor.sv
// Windowed max/min/peak/clip measurement of the FIR output stream, with a
// settling discard after reset or restart and a valid/ready result port.
module fir_output_range_monitor #(
  parameter int              DATA_WIDTH     = 32,
  parameter int              WINDOW_LEN     = 1024,
  parameter int              SETTLE_SAMPLES = 64,
  parameter longint unsigned CLIP_THRESH    = 64'd1 << 30,
  parameter int              CNT_WIDTH      = 16
) (
  input logic                      clk,
  input logic                      rst,
  fir_output_range_monitor_if.slave bus
);
  localparam int DW  = DATA_WIDTH;
  localparam int DW1 = DATA_WIDTH + 1;
  localparam int WW  = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam int SW  = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;

  localparam logic [WW-1:0]  WIN_LAST    = WW'(WINDOW_LEN - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);
  localparam logic [DW:0]    CLIP_T      = DW1'(CLIP_THRESH);
  localparam logic [DW-1:0]  MOST_NEG    = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]  MOST_POS    = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic {SETTLE, ACCUM} state_t;
  localparam state_t START = (SETTLE_SAMPLES > 0) ? SETTLE : ACCUM;

  typedef struct packed {
    logic signed [DW-1:0]        mx;
    logic signed [DW-1:0]        mn;
    logic        [DW-1:0]        pk;
    logic        [CNT_WIDTH-1:0] clip;
  } res_t;

  state_t state, state_n;

  logic [SW-1:0]          settle_cnt;
  logic [WW-1:0]          win_cnt;
  res_t                   acc, acc_n, res;
  logic                   res_valid;
  logic                   overrun_r;
  logic                   busy_r;

  logic signed [DW-1:0]   x;
  logic        [DW-1:0]   abs_x;
  logic                   clipped;
  logic                   take, acc_take, win_end, xfer, first;

  assign x        = bus.data_in;
  // restart wins over a coincident sample, which is simply dropped
  assign take     = bus.data_valid && !bus.restart;
  assign acc_take = take && (state == ACCUM);
  assign first    = (win_cnt == '0);
  assign win_end  = acc_take && (win_cnt == WIN_LAST);
  assign xfer     = res_valid && bus.result_ready;

  // |x| with the most-negative code pinned to the largest positive value
  always_comb begin
    abs_x = x;
    if (x[DW-1]) abs_x = (x == MOST_NEG) ? MOST_POS : DW'(-x);
  end

  assign clipped = ({1'b0, abs_x} >= CLIP_T);

  always_comb begin
    acc_n      = acc;
    acc_n.mx   = (first || x > acc.mx) ? x : acc.mx;
    acc_n.mn   = (first || x < acc.mn) ? x : acc.mn;
    acc_n.pk   = (abs_x > acc.pk) ? abs_x : acc.pk;
    acc_n.clip = (clipped && !(&acc.clip)) ? acc.clip + 1'b1 : acc.clip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= START;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.restart)
      state_n = START;
    else if (take && state == SETTLE && settle_cnt == SETTLE_LAST)
      state_n = ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      acc        <= '0;
      res        <= '0;
      res_valid  <= 1'b0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      busy_r <= (state_n == SETTLE);
      if (bus.restart) begin
        settle_cnt <= '0;
        win_cnt    <= '0;
        acc        <= '0;
        res        <= '0;
        res_valid  <= 1'b0;
        overrun_r  <= 1'b0;
      end else begin
        if (take && state == SETTLE)
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? '0 : settle_cnt + 1'b1;

        if (acc_take) begin
          if (win_end) begin
            win_cnt <= '0;
            acc     <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            acc     <= acc_n;
          end
        end

        // a finished window only replaces a result that is gone or leaving now
        if (win_end && (!res_valid || bus.result_ready)) begin
          res       <= acc_n;
          res_valid <= 1'b1;
        end else begin
          if (win_end) overrun_r <= 1'b1;
          if (xfer)    res_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.result_valid = res_valid;
  assign bus.max_val      = res.mx;
  assign bus.min_val      = res.mn;
  assign bus.peak_abs     = res.pk;
  assign bus.clip_count   = res.clip;
  assign bus.overrun      = overrun_r;
  assign bus.busy         = busy_r;
endmodule
